axis_header_sched: RTL and testbench
====================================

Name: axis_header_sched

Overview:
- Round-robin scheduler that shares the single header-insert port of the AXI-Stream header-insertion datapath between N header requesters.
- Grants one requester, registers its header (data, keep, byte count) and presents it on the insert port.
- Holds the grant until the last beat of the associated packet is observed on the datapath's input stream, then re-arbitrates.
- Flags orphan packets (data with no header) and stalled packets (timeout).

Parameters:
- N_REQ, 4, number of header requesters (2..8).
- DATA_WD, 32, header data width in bits.
- DATA_BYTE_WD, DATA_WD/8, keep width.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte-count width.
- ID_WD, (N_REQ>1 ? $clog2(N_REQ) : 1), grant index width.
- TIMEOUT, 1024, idle cycles allowed in PKT before abort (>=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester header valid.
- req_data  in  N_REQ*DATA_WD  packed headers; requester i at [i*DATA_WD +: DATA_WD].
- req_keep  in  N_REQ*DATA_BYTE_WD  packed header keeps.
- req_cnt  in  N_REQ*BYTE_CNT_WD  packed header byte counts.
- req_ready  out  N_REQ  one-hot accept pulse to the winning requester.
- valid_insert  out  1  header valid to the insert datapath.
- data_insert  out  DATA_WD  registered header data.
- keep_insert  out  DATA_BYTE_WD  registered header keep.
- byte_insert_cnt  out  BYTE_CNT_WD  registered header byte count.
- ready_insert  in  1  insert datapath accepts the header.
- mon_valid  in  1  datapath stream input valid (monitor only).
- mon_ready  in  1  datapath stream input ready (monitor only).
- mon_last  in  1  datapath stream input last (monitor only).
- grant_id  out  ID_WD  index of the current or last granted requester.
- busy  out  1  high in HDR or PKT.
- err_clr  in  1  synchronous clear for the sticky error flags.
- orphan_err  out  1  sticky: last beat seen while no packet is open.
- timeout_err  out  1  sticky: PKT stalled for TIMEOUT cycles.

Behaviour:
- Reset values:
  - state = IDLE; rr_ptr = 0.
  - valid_insert = 0; data_insert, keep_insert, byte_insert_cnt = 0.
  - grant_id = 0; busy = 0; both error flags = 0.
  - timeout counter = 0; req_ready = 0.
- Definitions:
  - beat = mon_valid & mon_ready.
  - eop = beat & mon_last.
- Arbitration:
  - Combinational round-robin search starting at rr_ptr, wrapping modulo N_REQ.
  - The winner is the first i with req_valid[i].
- IDLE:
  - If any req_valid is high: req_ready[winner] = 1 in this cycle (this is the handshake).
  - At the clock edge: capture the winner's data, keep and cnt; valid_insert <= 1; grant_id <= winner; state <= HDR.
  - If no req_valid: all req_ready = 0.
  - req_ready is asserted only in IDLE.
- HDR:
  - valid_insert stays 1; data, keep and cnt stay stable until accepted.
  - When ready_insert = 1: valid_insert <= 0; state <= PKT; timeout counter <= 0.
- PKT:
  - On eop: state <= IDLE; rr_ptr <= (grant_id == N_REQ-1) ? 0 : grant_id+1.
  - Latency: 1 cycle from eop to IDLE, next req_ready in the following cycle.
  - On beat without last: counter <= 0.
  - With no beat: counter increments.
  - When the counter reaches TIMEOUT-1 with no beat: timeout_err <= 1; state <= IDLE; rr_ptr advances as for eop.
- Orphan detection:
  - eop in IDLE or HDR sets orphan_err; state is unaffected.
- Simultaneous events:
  - err_clr together with a new error event: the event wins (flag = 1).
  - eop and the timeout terminal count in the same cycle: treated as eop; no timeout_err.
- busy is registered: 1 exactly while state is HDR or PKT.
- Reset mid-operation: immediate return to reset values. An in-flight header is dropped and no req_ready is reissued for it; the requester keeps req_valid asserted.
- N_REQ = 2..8 only; ID_WD arithmetic wraps explicitly, with no reliance on power-of-two N.

Test Plan:
- Single requester: req_valid[0] with data 0xA1B2C3D4, keep 0xF, cnt 2 -> req_ready[0] pulses 1 cycle; next cycle valid_insert=1 with those values; ready_insert=1 -> PKT; 3-beat packet ending with eop -> IDLE 1 cycle later, rr_ptr=1.
- Contention: req_valid=4'b1111 held, 4 packets -> grant_id sequence 0,1,2,3 then 0; at most one req_ready bit set per cycle.
- Insert backpressure: ready_insert low for 5 cycles in HDR -> valid_insert and data_insert unchanged for all 5 cycles; no req_ready pulses during HDR.
- Orphan: mon_valid=mon_ready=mon_last=1 in IDLE -> orphan_err=1 next cycle and stays 1; err_clr -> 0; err_clr together with another eop in IDLE -> 1.
- Timeout: TIMEOUT=16, enter PKT, no beats -> timeout_err=1 after 16 cycles, state IDLE, rr_ptr advanced; same case with a beat at cycle 10 -> no error until 16 idle cycles after the beat.
- Reset mid-PKT: assert rst_n=0 asynchronously -> busy, valid_insert and grant_id go to 0 without waiting for a clock edge; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/axis_header_sched_if.sv
// Bundles the requester headers, the header-insert port and the stream monitor taps
// of the header scheduler. Requester i occupies lane i of each packed vector.
interface axis_header_sched_if #(
  parameter int N_REQ        = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ*DATA_WD-1:0]      req_data;
  logic [N_REQ*DATA_BYTE_WD-1:0] req_keep;
  logic [N_REQ*BYTE_CNT_WD-1:0]  req_cnt;
  logic [N_REQ-1:0]              req_ready;

  logic                          valid_insert;
  logic [DATA_WD-1:0]            data_insert;
  logic [DATA_BYTE_WD-1:0]       keep_insert;
  logic [BYTE_CNT_WD-1:0]        byte_insert_cnt;
  logic                          ready_insert;

  logic                          mon_valid;
  logic                          mon_ready;
  logic                          mon_last;

  modport master (
    output req_valid, req_data, req_keep, req_cnt, ready_insert,
           mon_valid, mon_ready, mon_last,
    input  req_ready, valid_insert, data_insert, keep_insert, byte_insert_cnt
  );

  modport slave (
    input  req_valid, req_data, req_keep, req_cnt, ready_insert,
           mon_valid, mon_ready, mon_last,
    output req_ready, valid_insert, data_insert, keep_insert, byte_insert_cnt
  );
endinterface

// File: rtl/axis_header_sched.sv
// Round-robin scheduler sharing one header-insert port among N_REQ requesters; the grant
// is held until the packet's last beat, with orphan-packet and stall-timeout detection.
module axis_header_sched #(
  parameter int N_REQ        = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int ID_WD        = (N_REQ > 1 ? $clog2(N_REQ) : 1),
  parameter int TIMEOUT      = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axis_header_sched_if.slave   bus,
  output logic [ID_WD-1:0]     grant_id,
  output logic                 busy,
  input  logic                 err_clr,
  output logic                 orphan_err,
  output logic                 timeout_err
);

  localparam int TMR_WD = $clog2(TIMEOUT);
  localparam logic [TMR_WD-1:0] TMR_MAX = TMR_WD'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PKT  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [ID_WD-1:0]  rr_ptr;
  logic [TMR_WD-1:0] tmo_cnt, cnt_next;

  logic              beat, eop;
  logic              any_valid;
  logic [ID_WD-1:0]  winner;
  logic              hi_hit, lo_hit;
  logic [ID_WD-1:0]  hi_idx, lo_idx;
  logic              capture, pkt_done, tmo_hit, orphan_hit;

  assign beat = bus.mon_valid & bus.mon_ready;
  assign eop  = beat & bus.mon_last;

  // Lowest requester at or above rr_ptr wins; otherwise the lowest one below it (wrap).
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (ID_WD'(i) >= rr_ptr) begin
          hi_hit = 1'b1;
          hi_idx = ID_WD'(i);
        end else begin
          lo_hit = 1'b1;
          lo_idx = ID_WD'(i);
        end
      end
    end
    any_valid = hi_hit | lo_hit;
    winner    = hi_hit ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.req_ready = '0;
    capture       = 1'b0;
    pkt_done      = 1'b0;
    tmo_hit       = 1'b0;
    cnt_next      = tmo_cnt;
    case (state)
      IDLE: begin
        // Gated by rst_n so no accept pulse escapes while reset is held.
        if (any_valid && rst_n) begin
          bus.req_ready = N_REQ'(1) << winner;
          capture       = 1'b1;
          state_next    = HDR;
        end
      end
      HDR: begin
        if (bus.ready_insert) begin
          state_next = PKT;
          cnt_next   = '0;
        end
      end
      PKT: begin
        if (eop) begin
          state_next = IDLE;
          pkt_done   = 1'b1;
        end else if (beat) begin
          cnt_next = '0;
        end else if (tmo_cnt == TMR_MAX) begin
          state_next = IDLE;
          pkt_done   = 1'b1;
          tmo_hit    = 1'b1;
        end else begin
          cnt_next = tmo_cnt + TMR_WD'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    orphan_hit = eop && (state != PKT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_insert    <= 1'b0;
      bus.data_insert     <= '0;
      bus.keep_insert     <= '0;
      bus.byte_insert_cnt <= '0;
      grant_id            <= '0;
    end else if (capture) begin
      bus.valid_insert    <= 1'b1;
      bus.data_insert     <= bus.req_data[winner*DATA_WD +: DATA_WD];
      bus.keep_insert     <= bus.req_keep[winner*DATA_BYTE_WD +: DATA_BYTE_WD];
      bus.byte_insert_cnt <= bus.req_cnt[winner*BYTE_CNT_WD +: BYTE_CNT_WD];
      grant_id            <= winner;
    end else if (state == HDR && bus.ready_insert) begin
      bus.valid_insert    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
      busy        <= 1'b0;
      orphan_err  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt <= cnt_next;
      busy    <= (state_next != IDLE);
      if (pkt_done)
        rr_ptr <= (grant_id == ID_WD'(N_REQ - 1)) ? '0 : grant_id + ID_WD'(1);
      if (orphan_hit)   orphan_err <= 1'b1;
      else if (err_clr) orphan_err <= 1'b0;
      if (tmo_hit)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_header_sched.sv
// Directed bench for axis_header_sched: handshake, round-robin order, insert backpressure,
// orphan/timeout flags and asynchronous reset, all against hand-computed values.
module tb_axis_header_sched;
  localparam int N_REQ        = 4;
  localparam int DATA_WD      = 32;
  localparam int DATA_BYTE_WD = 4;
  localparam int BYTE_CNT_WD  = 2;
  localparam int ID_WD        = 2;
  localparam int TIMEOUT      = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             err_clr = 1'b0;
  logic [ID_WD-1:0] grant_id;
  logic             busy, orphan_err, timeout_err;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_data [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
  logic [3:0]  exp_keep [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [1:0]  exp_cnt  [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

  axis_header_sched_if #(.N_REQ(N_REQ), .DATA_WD(DATA_WD)) bus ();

  axis_header_sched #(
    .N_REQ(N_REQ), .DATA_WD(DATA_WD), .DATA_BYTE_WD(DATA_BYTE_WD),
    .BYTE_CNT_WD(BYTE_CNT_WD), .ID_WD(ID_WD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .grant_id(grant_id), .busy(busy),
    .err_clr(err_clr), .orphan_err(orphan_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic r, input logic l);
    bus.mon_valid = v;
    bus.mon_ready = r;
    bus.mon_last  = l;
  endtask

  task automatic loadReq(input int i, input logic [31:0] d, input logic [3:0] k, input logic [1:0] c);
    bus.req_data[i*DATA_WD +: DATA_WD]           = d;
    bus.req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD] = k;
    bus.req_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD]    = c;
  endtask

  task automatic checkHeader(input string tag, input int g, input logic [31:0] d,
                             input logic [3:0] k, input logic [1:0] c);
    checkOutput({tag, "_valid"}, 64'(bus.valid_insert), 64'(1'b1));
    checkOutput({tag, "_gid"},   64'(grant_id), 64'(g));
    checkOutput({tag, "_data"},  64'(bus.data_insert), 64'(d));
    checkOutput({tag, "_keep"},  64'(bus.keep_insert), 64'(k));
    checkOutput({tag, "_cnt"},   64'(bus.byte_insert_cnt), 64'(c));
  endtask

  initial begin
    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.req_keep     = '0;
    bus.req_cnt      = '0;
    bus.ready_insert = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset state, with a requester already waiting.
    loadReq(0, 32'hA1B2_C3D4, 4'hF, 2'd2);
    bus.req_valid = 4'b0001;
    #3;
    checkOutput("rst_busy",    64'(busy), 64'(1'b0));
    checkOutput("rst_valid",   64'(bus.valid_insert), 64'(1'b0));
    checkOutput("rst_data",    64'(bus.data_insert), 64'(0));
    checkOutput("rst_keep",    64'(bus.keep_insert), 64'(0));
    checkOutput("rst_cnt",     64'(bus.byte_insert_cnt), 64'(0));
    checkOutput("rst_gid",     64'(grant_id), 64'(0));
    checkOutput("rst_orphan",  64'(orphan_err), 64'(1'b0));
    checkOutput("rst_timeout", 64'(timeout_err), 64'(1'b0));
    checkOutput("rst_ready",   64'(bus.req_ready), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Single requester handshake and header presentation.
    checkOutput("single_ready", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    checkHeader("single_hdr", 0, 32'hA1B2_C3D4, 4'hF, 2'd2);
    checkOutput("single_busy", 64'(busy), 64'(1'b1));
    checkOutput("single_ready_off", 64'(bus.req_ready), 64'(0));
    for (int i = 0; i < 4; i++) loadReq(i, exp_data[i], exp_keep[i], exp_cnt[i]);
    bus.req_valid = 4'b1111;

    // Insert backpressure: header frozen, no accept pulses while in HDR.
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_valid", 64'(bus.valid_insert), 64'(1'b1));
      checkOutput("bp_data",  64'(bus.data_insert), 64'(32'hA1B2_C3D4));
      checkOutput("bp_ready", 64'(bus.req_ready), 64'(0));
    end
    bus.ready_insert = 1'b1;
    tick();
    bus.ready_insert = 1'b0;
    checkOutput("pkt_valid", 64'(bus.valid_insert), 64'(1'b0));
    checkOutput("pkt_busy",  64'(busy), 64'(1'b1));
    checkOutput("pkt_ready", 64'(bus.req_ready), 64'(0));
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("eop_busy",   64'(busy), 64'(1'b0));
    checkOutput("eop_orphan", 64'(orphan_err), 64'(1'b0));
    #1;
    checkOutput("eop_rr1", 64'(bus.req_ready), 64'(4'b0010));

    // Contention: all requesters valid, grants rotate 1,2,3,0,1.
    for (int n = 0; n < 5; n++) begin
      int g;
      g = (n + 1) % 4;
      checkOutput("rr_ready", 64'(bus.req_ready), 64'(4'b0001 << g));
      tick();
      checkHeader("rr_hdr", g, exp_data[g], exp_keep[g], exp_cnt[g]);
      checkOutput("rr_hdr_ready", 64'(bus.req_ready), 64'(0));
      bus.ready_insert = 1'b1;
      tick();
      bus.ready_insert = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("rr_idle", 64'(busy), 64'(1'b0));
    end
    bus.req_valid = '0;

    // Orphan detection in IDLE and sticky clear behaviour.
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("orph_noready", 64'(orphan_err), 64'(1'b0));
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("orph_set",  64'(orphan_err), 64'(1'b1));
    checkOutput("orph_busy", 64'(busy), 64'(1'b0));
    tick();
    checkOutput("orph_sticky", 64'(orphan_err), 64'(1'b1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("orph_clr", 64'(orphan_err), 64'(1'b0));
    err_clr = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    err_clr = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("orph_clr_vs_set", 64'(orphan_err), 64'(1'b1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Timeout with no beats; rr_ptr is 2 so requester 0 is found by wrapping.
    bus.req_valid = 4'b0001;
    #1;
    checkOutput("tmo_wrap_ready", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    bus.req_valid = '0;
    checkOutput("tmo_gid", 64'(grant_id), 64'(0));
    bus.ready_insert = 1'b1;
    tick();
    bus.ready_insert = 1'b0;
    repeat (15) tick();
    checkOutput("tmo_pre_busy", 64'(busy), 64'(1'b1));
    checkOutput("tmo_pre_err",  64'(timeout_err), 64'(1'b0));
    tick();
    checkOutput("tmo_err",  64'(timeout_err), 64'(1'b1));
    checkOutput("tmo_busy", 64'(busy), 64'(1'b0));
    bus.req_valid = 4'b1111;
    #1;
    checkOutput("tmo_rr_adv", 64'(bus.req_ready), 64'(4'b0010));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    bus.req_valid = '0;
    checkOutput("tmo_clr", 64'(timeout_err), 64'(1'b0));
    checkOutput("tmo2_gid", 64'(grant_id), 64'(1));

    // A beat at idle cycle 10 restarts the stall window.
    bus.ready_insert = 1'b1;
    tick();
    bus.ready_insert = 1'b0;
    repeat (10) tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (15) tick();
    checkOutput("tmo2_pre_busy", 64'(busy), 64'(1'b1));
    checkOutput("tmo2_pre_err",  64'(timeout_err), 64'(1'b0));
    tick();
    checkOutput("tmo2_err",  64'(timeout_err), 64'(1'b1));
    checkOutput("tmo2_busy", 64'(busy), 64'(1'b0));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // eop on the terminal-count cycle ends the packet without a timeout.
    bus.req_valid = 4'b0100;
    #1;
    checkOutput("tc_ready", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    bus.req_valid = '0;
    bus.ready_insert = 1'b1;
    tick();
    bus.ready_insert = 1'b0;
    repeat (15) tick();
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("tc_no_tmo", 64'(timeout_err), 64'(1'b0));
    checkOutput("tc_busy",   64'(busy), 64'(1'b0));

    // Asynchronous reset in PKT, then arbitration restarts from requester 0.
    bus.req_valid = 4'b1000;
    #1;
    checkOutput("ar_ready", 64'(bus.req_ready), 64'(4'b1000));
    tick();
    bus.req_valid = '0;
    bus.ready_insert = 1'b1;
    tick();
    bus.ready_insert = 1'b0;
    tick();
    checkOutput("ar_pre_busy", 64'(busy), 64'(1'b1));
    checkOutput("ar_pre_gid",  64'(grant_id), 64'(3));
    bus.req_valid = 4'b1111;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_busy",  64'(busy), 64'(1'b0));
    checkOutput("ar_valid", 64'(bus.valid_insert), 64'(1'b0));
    checkOutput("ar_gid",   64'(grant_id), 64'(0));
    checkOutput("ar_ready_held", 64'(bus.req_ready), 64'(0));
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("ar_restart_ready", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    checkHeader("ar_restart_hdr", 0, exp_data[0], exp_keep[0], exp_cnt[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
